// File: rtl/multiplier_16x16b_iter.sv
// Iterative 16x16 -> 16-bit (low half) multiplier with val/rdy handshakes.
// Two multiplier bits are retired per cycle through a combinational 2x16
// partial-product unit, so every operation takes exactly 8 CALC cycles.

// Combinational 2x16 partial product: prod = in0 * in1 (mod 2^16).
module Multiplier_2x16b_GL (
    input  logic [15:0] in0,
    input  logic [1:0]  in1,
    output logic [15:0] prod
);

    // Select 0, in0, 2*in0 or 3*in0 from the two multiplier bits.
    always_comb begin
        prod = 16'h0000;
        case (in1)
            2'd0:    prod = 16'h0000;
            2'd1:    prod = in0;
            2'd2:    prod = in0 << 1;
            2'd3:    prod = in0 + (in0 << 1);
            default: prod = 16'h0000;
        endcase
    end

endmodule

module multiplier_16x16b_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [15:0] prod
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Only the low 16 bits of the product are kept, and those are identical
    // for signed and unsigned operands, so the datapath stays unsigned.
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] acc;
    logic [2:0]  cnt;
    logic [15:0] pp;

    Multiplier_2x16b_GL u_pp (
        .in0  (a),
        .in1  (b[1:0]),
        .prod (pp)
    );

    // State register; reset always returns to IDLE, aborting any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; outputs depend on state only.
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_val   = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                // Fixed 8 iterations; no early exit when b runs out of ones.
                if (cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift-and-add datapath: load on accept, accumulate while in CALC, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= 16'h0000;
            b   <= 16'h0000;
            acc <= 16'h0000;
            cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_val) begin
                        a   <= in0;
                        b   <= in1;
                        acc <= 16'h0000;
                        cnt <= 3'd0;
                    end
                end
                CALC: begin
                    acc <= acc + pp;
                    a   <= a << 2;
                    b   <= b >> 2;
                    cnt <= cnt + 3'd1;
                end
                default: begin
                    a   <= a;
                    b   <= b;
                    acc <= acc;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign prod = acc;

endmodule

// File: tb/tb_multiplier_16x16b_iter.sv
// Scoreboard bench for multiplier_16x16b_iter: directed corner cases,
// backpressure, mid-operation reset and a random back-to-back run.
`timescale 1ns/1ps

module tb_multiplier_16x16b_iter;

    logic        clk;
    logic        rst;
    logic        in_val;
    logic        in_rdy;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] prod;

    logic        rdy_dir;
    logic        rnd_bit;
    logic        rand_mode;
    logic        ov_prev;

    int          cyc;
    int          total;
    int          bad;
    int          n_sent;
    int          n_abort;
    int          n_out;

    logic [15:0] exp_q[$];
    int          acc_q[$];

    multiplier_16x16b_iter dut (
        .clk     (clk),
        .rst     (rst),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in0     (in0),
        .in1     (in1),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .prod    (prod)
    );

    assign out_rdy = rand_mode ? rnd_bit : rdy_dir;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer stalls, changed just after each rising edge.
    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: latency on each out_val rise, product on each handshake.
    initial ov_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_val && !ov_prev) begin
                if (acc_q.size() == 0) chk("unexpected_out_val", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - acc_q[0]), 32'd9);
            end
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", 32'd1, 32'd0);
                end else begin
                    chk("prod", {16'h0, prod}, {16'h0, exp_q.pop_front()});
                    void'(acc_q.pop_front());
                    n_out = n_out + 1;
                end
            end
        end
        ov_prev <= out_val;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, wait for acceptance, record the expectation.
    task automatic send(input logic [15:0] x, input logic [15:0] y);
        int tries;
        tries = 0;
        while (!in_rdy && tries < 200) begin
            step();
            tries++;
        end
        if (!in_rdy) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            in0    = x;
            in1    = y;
            in_val = 1'b1;
            exp_q.push_back(16'(32'(x) * 32'(y)));
            acc_q.push_back(cyc);
            n_sent = n_sent + 1;
            step();
            in_val = 1'b0;
        end
    endtask

    task automatic wait_out();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_val) seen = 1'b1;
        end
        if (!seen) chk("wait_out_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        total     = 0;
        bad       = 0;
        n_sent    = 0;
        n_abort   = 0;
        n_out     = 0;
        rst       = 1'b1;
        in_val    = 1'b0;
        in0       = 16'h0;
        in1       = 16'h0;
        rdy_dir   = 1'b0;
        rand_mode = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_prod", {16'h0, prod}, 32'd0);

        // Basic product with a ready consumer.
        step();
        rdy_dir = 1'b1;
        send(16'd3, 16'd5);
        wait_out();
        @(negedge clk);
        chk("basic_in_rdy_after", 32'(in_rdy), 32'd1);
        chk("basic_out_val_after", 32'(out_val), 32'd0);

        // Wrap-around and zero-multiplier corner cases.
        send(16'hFFFF, 16'hFFFF);
        send(16'h00FF, 16'h0101);
        send(16'h0100, 16'h0100);
        send(16'h1234, 16'h0000);
        drain();

        // Backpressure: hold result for 5 cycles while in_val pulses.
        step();
        rdy_dir = 1'b0;
        send(16'h0007, 16'h0009);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            step();
            in_val = 1'b1;
            in0    = 16'(i + 100);
            in1    = 16'(i + 7);
            @(negedge clk);
            chk("bp_out_val", 32'(out_val), 32'd1);
            chk("bp_prod_hold", {16'h0, prod}, 32'h3F);
            chk("bp_in_rdy", 32'(in_rdy), 32'd0);
        end
        step();
        in_val  = 1'b0;
        rdy_dir = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_rdy_release", 32'(in_rdy), 32'd1);
        chk("bp_out_val_release", 32'(out_val), 32'd0);

        // Reset in the middle of CALC aborts the operation.
        send(16'h1111, 16'h0003);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        n_abort = n_abort + 1;
        @(negedge clk);
        chk("abort_in_rdy", 32'(in_rdy), 32'd1);
        chk("abort_out_val", 32'(out_val), 32'd0);
        chk("abort_prod", {16'h0, prod}, 32'd0);
        step();
        send(16'd2, 16'd2);
        drain();

        // Random back-to-back traffic with random consumer stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            send(16'($urandom), 16'($urandom));
        end
        drain();
        rand_mode = 1'b0;
        repeat (3) step();

        chk("output_count", 32'(n_out), 32'(n_sent - n_abort));
        chk("final_in_rdy", 32'(in_rdy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
